// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared constants for the parameterised serial sequence detector
package seq_pkg;

    localparam int              SEQ_DEFAULT_N       = 4;
    localparam logic [3:0]      SEQ_DEFAULT_PATTERN = 4'b1001;
    localparam int              SEQ_DEFAULT_CW      = 8;
    localparam int              SEQ_N_MIN           = 2;
    localparam int              SEQ_N_MAX           = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter, holds at all-ones instead of wrapping
module sat_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [CW-1:0] q
);

    localparam logic [CW-1:0] L_MAX = '1;

    // count up on inc, stick at the maximum value
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != L_MAX)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - serial pattern detector with runtime reload and match counter
module seq_detect_param
    import seq_pkg::*;
#(
    parameter int N       = SEQ_DEFAULT_N,
    parameter     PATTERN = SEQ_DEFAULT_PATTERN,
    parameter bit OVERLAP = 1'b1,
    parameter int CW      = SEQ_DEFAULT_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a,
    input  logic          en,
    input  logic          load,
    input  logic [N-1:0]  pat_in,
    output logic          out,
    output logic [CW-1:0] count
);

    localparam int             FW       = (N > 2) ? $clog2(N) : 1;
    localparam logic [FW-1:0]  L_FULL   = FW'(N - 1);
    localparam logic [N-1:0]   L_PAT    = N'(PATTERN);

    // Reject illegal lengths and patterns whose width disagrees with N
    generate
        if ((N < SEQ_N_MIN) || (N > SEQ_N_MAX)) begin : g_bad_n
            $error("seq_detect_param: N out of legal range");
        end
        if ($bits(PATTERN) != N) begin : g_bad_pattern
            $error("seq_detect_param: PATTERN width differs from N");
        end
    endgenerate

    logic [N-2:0]  r_hist;
    logic [FW-1:0] r_fill;
    logic [N-1:0]  r_pat;
    logic          r_out;

    logic [N-1:0]  w_window;
    logic          w_full;
    logic          w_match;

    // The candidate window is the stored history plus the bit arriving now
    assign w_window = {r_hist, a};
    assign w_full   = (r_fill == L_FULL);
    assign w_match  = en & ~load & w_full & (w_window == r_pat);

    // History, fill level, active pattern and registered match pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= L_PAT;
            r_out  <= 1'b0;
        end else if (load) begin
            // fill restarts so bits from before the reload never complete a match
            r_pat  <= pat_in;
            r_fill <= '0;
            r_out  <= 1'b0;
        end else if (en) begin
            r_hist <= w_window[N-2:0];
            r_out  <= w_match;
            if (w_match && !OVERLAP) begin
                r_fill <= '0;
            end else if (!w_full) begin
                r_fill <= r_fill + 1'b1;
            end
        end else begin
            r_out  <= 1'b0;
        end
    end

    assign out = r_out;

    sat_counter #(
        .CW (CW)
    ) u_match_count (
        .clk (clk),
        .rst (rst),
        .inc (w_match),
        .q   (count)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - directed self-checking bench for seq_detect_param
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       a;
    logic       en;
    logic       load;
    logic [3:0] pat_in;
    logic [1:0] pat_in2;

    logic       out_d, out_n, out_c, out_2;
    logic [7:0] count_d, count_n, count_2;
    logic [1:0] count_c;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    seq_detect_param dut_d (
        .clk (clk), .rst (rst), .a (a), .en (en), .load (load),
        .pat_in (pat_in), .out (out_d), .count (count_d)
    );

    seq_detect_param #(.OVERLAP(1'b0)) dut_n (
        .clk (clk), .rst (rst), .a (a), .en (en), .load (load),
        .pat_in (pat_in), .out (out_n), .count (count_n)
    );

    seq_detect_param #(.CW(2)) dut_c (
        .clk (clk), .rst (rst), .a (a), .en (en), .load (load),
        .pat_in (pat_in), .out (out_c), .count (count_c)
    );

    seq_detect_param #(.N(2), .PATTERN(2'b11)) dut_2 (
        .clk (clk), .rst (rst), .a (a), .en (en), .load (load),
        .pat_in (pat_in2), .out (out_2), .count (count_2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic ai, input logic eni, input logic ldi);
        a    = ai;
        en   = eni;
        load = ldi;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        a    = 1'b0;
        en   = 1'b0;
        load = 1'b0;
        @(posedge clk);
        #1;
        rst  = 1'b0;
    endtask

    // Drive len bits MSB first with en=1 and check out on the overlap and non-overlap instances
    task automatic run_stream(input string tag, input logic [31:0] bits,
                              input logic [31:0] exp_d, input logic [31:0] exp_n, input int len);
        for (int i = 0; i < len; i++) begin
            step(bits[len-1-i], 1'b1, 1'b0);
            check($sformatf("%s_ovl_b%0d", tag, i + 1), 32'(out_d), 32'(exp_d[len-1-i]));
            check($sformatf("%s_nov_b%0d", tag, i + 1), 32'(out_n), 32'(exp_n[len-1-i]));
        end
    endtask

    int exp_c [19] = '{0,0,0,1,1,1,2,2,2,3,3,3,3,3,3,3,3,3,3};

    initial begin
        rst     = 1'b0;
        a       = 1'b0;
        en      = 1'b0;
        load    = 1'b0;
        pat_in  = 4'b0000;
        pat_in2 = 2'b11;

        // reset state
        do_reset();
        check("rst_out", 32'(out_d), 32'd0);
        check("rst_count", 32'(count_d), 32'd0);
        check("rst_count_c", 32'(count_c), 32'd0);

        // 1001001: overlap pulses after bits 4 and 7, non-overlap only after 4
        run_stream("ovl", 32'b1001001, 32'b0001001, 32'b0001000, 7);
        check("ovl_count", 32'(count_d), 32'd2);
        check("nov_count", 32'(count_n), 32'd1);

        // reload mid-stream: stale bits must not complete a match under 0110
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        pat_in = 4'b0110;
        step(1'b1, 1'b1, 1'b1);
        check("load_out", 32'(out_d), 32'd0);
        check("load_count_hold", 32'(count_d), 32'd0);
        begin
            logic [4:0] lb;
            logic [4:0] le;
            lb = 5'b10110;
            le = 5'b00001;
            for (int i = 0; i < 5; i++) begin
                step(lb[4-i], 1'b1, 1'b0);
                check($sformatf("reload_b%0d", i + 1), 32'(out_d), 32'(le[4-i]));
            end
        end
        check("reload_count", 32'(count_d), 32'd1);

        // enable gaps hold state and force out low
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check($sformatf("en_gap_%0d", i), 32'(out_d), 32'd0);
        end
        step(1'b0, 1'b1, 1'b0);
        check("en_resume_b3", 32'(out_d), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        check("en_resume_b4", 32'(out_d), 32'd1);
        check("en_count", 32'(count_d), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        check("en_pulse_end", 32'(out_d), 32'd0);

        // saturating 2-bit counter across six overlapping matches
        do_reset();
        begin
            logic [18:0] sb;
            sb = 19'b1001001001001001001;
            for (int i = 0; i < 19; i++) begin
                step(sb[18-i], 1'b1, 1'b0);
                check($sformatf("sat_b%0d", i + 1), 32'(count_c), 32'(exp_c[i]));
            end
        end
        check("sat_wide_count", 32'(count_d), 32'd6);

        // reset mid-pattern discards progress
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        check("midrst_out", 32'(out_d), 32'd0);
        check("midrst_count", 32'(count_d), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        check("midrst_after", 32'(out_d), 32'd0);
        check("midrst_after_count", 32'(count_d), 32'd0);

        // N=2 pattern 11: consecutive matches give a two-cycle-high out
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        check("n2_b1", 32'(out_2), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        check("n2_b2", 32'(out_2), 32'd1);
        step(1'b1, 1'b1, 1'b0);
        check("n2_b3", 32'(out_2), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        check("n2_b4", 32'(out_2), 32'd0);
        check("n2_count", 32'(count_2), 32'd2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
